// File: rtl/attack_scheduler_if.sv
// rtl/attack_scheduler_if.sv - runtime, attack-ROM and spawn signals of the attack scheduler
interface attack_scheduler_if #(
    parameter int TIME_W  = 30,
    parameter int INDEX_W = 20
);
    logic [TIME_W-1:0]  current_time;
    logic [INDEX_W-1:0] attack_i;
    logic               sync_attack_time;
    logic               is_reset_stage;
    logic [INDEX_W-1:0] rom_addr;
    logic [39:0]        rom_data;
    logic [TIME_W-1:0]  next_attack_time;
    logic               update_attack_time;
    logic               spawn_valid;
    logic [3:0]         spawn_type;
    logic [9:0]         spawn_x;
    logic [9:0]         spawn_y;
    logic [7:0]         spawn_lifetime;
    logic [15:0]        spawn_count;

    modport master (
        output current_time, attack_i, sync_attack_time, is_reset_stage, rom_data,
        input  rom_addr, next_attack_time, update_attack_time,
        input  spawn_valid, spawn_type, spawn_x, spawn_y, spawn_lifetime, spawn_count
    );

    modport slave (
        input  current_time, attack_i, sync_attack_time, is_reset_stage, rom_data,
        output rom_addr, next_attack_time, update_attack_time,
        output spawn_valid, spawn_type, spawn_x, spawn_y, spawn_lifetime, spawn_count
    );
endinterface

// File: rtl/attack_scheduler.sv
// rtl/attack_scheduler.sv - fetches attack records, reports their spawn time and fires spawn events
module attack_scheduler #(
    parameter int TIME_W  = 30,
    parameter int INDEX_W = 20
) (
    input  logic               clk,
    input  logic               reset,
    attack_scheduler_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, ACK, ARMED} state_t;

    state_t             state_q, state_d;
    logic [INDEX_W-1:0] rom_addr_q, rom_addr_d;
    logic [INDEX_W-1:0] armed_index_q, armed_index_d;
    logic [39:0]        rec_q, rec_d;
    logic [TIME_W-1:0]  next_time_q, next_time_d;
    logic               update_q, update_d;
    logic               spawn_valid_q, spawn_valid_d;
    logic [31:0]        spawn_rec_q, spawn_rec_d;
    logic [15:0]        spawn_count_q, spawn_count_d;
    logic [7:0]         delay;
    logic [TIME_W-1:0]  due_time;

    // In LATCH the record is still on the ROM bus, so take the delay straight from it
    assign delay    = (state_q == LATCH) ? bus.rom_data[39:32] : rec_q[39:32];
    assign due_time = bus.current_time + {{(TIME_W-8){1'b0}}, delay};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rom_addr_q    <= '0;
            armed_index_q <= '0;
            rec_q         <= '0;
            next_time_q   <= '0;
            update_q      <= 1'b0;
            spawn_valid_q <= 1'b0;
            spawn_rec_q   <= '0;
            spawn_count_q <= '0;
        end else begin
            state_q       <= state_d;
            rom_addr_q    <= rom_addr_d;
            armed_index_q <= armed_index_d;
            rec_q         <= rec_d;
            next_time_q   <= next_time_d;
            update_q      <= update_d;
            spawn_valid_q <= spawn_valid_d;
            spawn_rec_q   <= spawn_rec_d;
            spawn_count_q <= spawn_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rom_addr_d    = rom_addr_q;
        armed_index_d = armed_index_q;
        rec_d         = rec_q;
        next_time_d   = next_time_q;
        update_d      = 1'b0;
        spawn_valid_d = 1'b0;
        spawn_rec_d   = spawn_rec_q;
        spawn_count_d = spawn_count_q;
        if (bus.is_reset_stage) begin
            state_d = IDLE;
            rec_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.sync_attack_time) begin
                        state_d    = FETCH;
                        rom_addr_d = bus.attack_i;
                    end
                end
                FETCH: state_d = LATCH;
                LATCH: begin
                    rec_d         = bus.rom_data;
                    armed_index_d = rom_addr_q;
                    state_d       = ACK;
                    update_d      = 1'b1;
                    next_time_d   = due_time;
                end
                ACK: begin
                    // Keep re-acknowledging with a fresh time until the runtime accepts
                    if (bus.sync_attack_time) begin
                        state_d = ARMED;
                    end else begin
                        update_d    = 1'b1;
                        next_time_d = due_time;
                    end
                end
                ARMED: begin
                    if (bus.attack_i != armed_index_q) begin
                        spawn_valid_d = 1'b1;
                        spawn_rec_d   = rec_q[31:0];
                        spawn_count_d = spawn_count_q + 16'd1;
                        if (!bus.sync_attack_time) begin
                            state_d    = FETCH;
                            rom_addr_d = bus.attack_i;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.rom_addr           = rom_addr_q;
    assign bus.next_attack_time   = next_time_q;
    assign bus.update_attack_time = update_q;
    assign bus.spawn_valid        = spawn_valid_q;
    assign bus.spawn_type         = spawn_rec_q[31:28];
    assign bus.spawn_x            = spawn_rec_q[27:18];
    assign bus.spawn_y            = spawn_rec_q[17:8];
    assign bus.spawn_lifetime     = spawn_rec_q[7:0];
    assign bus.spawn_count        = spawn_count_q;
endmodule

// File: doc/attack_scheduler.md
ATTACK_SCHEDULER -- requirements
Module: attack_scheduler

Interface
REQ-001 SHALL have parameter TIME_W, default 30, width of time values.
REQ-002 SHALL have parameter INDEX_W, default 20, width of attack index.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port current_time  input  TIME_W  game time from runtime, in runtime time units.
REQ-006 SHALL have port attack_i  input  INDEX_W  runtime's current attack index.
REQ-007 SHALL have port sync_attack_time  input  1  runtime ready flag; 0 = new spawn time requested.
REQ-008 SHALL have port is_reset_stage  input  1  runtime game-over/restart flag.
REQ-009 SHALL have port rom_addr  output  INDEX_W  registered attack-ROM address.
REQ-010 SHALL have port rom_data  input  40  ROM word: [39:32] delay, [31:28] type, [27:18] x, [17:8] y, [7:0] lifetime.
REQ-011 SHALL have port next_attack_time  output  TIME_W  absolute time of the pending attack.
REQ-012 SHALL have port update_attack_time  output  1  acknowledge to runtime; next_attack_time valid.
REQ-013 SHALL have ports spawn_valid (1), spawn_type (4), spawn_x (10), spawn_y (10), spawn_lifetime (8), all outputs: spawn event and its fields.
REQ-014 SHALL have port spawn_count  output  16  number of spawns since reset.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, LATCH, ACK, ARMED.
REQ-016 IDLE: if is_reset_stage=0 and sync_attack_time=0, go to FETCH; otherwise stay.
REQ-017 FETCH: rom_addr <= attack_i on entry; hold for one cycle; go to LATCH.
REQ-018 LATCH: sample rom_data (synchronous ROM, 1-cycle read latency) into a held record; record armed_index = rom_addr; go to ACK.
REQ-019 ACK: update_attack_time=1 and next_attack_time <= current_time + delay, recomputed every cycle; go to ARMED when sync_attack_time=1.
REQ-020 ACK update pulse is level-held, so an acknowledge issued while the runtime is between stages is repeated until accepted; the latest accepted time is measured from stage start.
REQ-021 ARMED: update_attack_time=0; next_attack_time held; when attack_i != armed_index, pulse spawn_valid for exactly one cycle with the held record and increment spawn_count.
REQ-022 From ARMED on a spawn, go to FETCH if sync_attack_time=0 that cycle (mid-stage spawn); otherwise go to IDLE (stage-ending spawn).
REQ-023 Time addition SHALL be modulo 2^TIME_W; delay is zero-extended.
REQ-024 delay=0 SHALL be legal and yield next_attack_time = current_time.
REQ-025 spawn_type/x/y/lifetime SHALL hold the last spawned values until the next spawn_valid.
REQ-026 spawn_count SHALL wrap from 65535 to 0.
REQ-027 is_reset_stage=1 in any state SHALL force IDLE next cycle, with update_attack_time=0, spawn_valid=0, and the held record discarded with no spawn.
REQ-028 If is_reset_stage=1 and an attack_i change occur in the same cycle, is_reset_stage wins and there is no spawn.
REQ-029 Latency: sync_attack_time falling to the first update_attack_time=1 SHALL be 3 cycles (IDLE/ARMED->FETCH->LATCH->ACK).

Reset
REQ-030 On reset: state=IDLE, rom_addr=0, next_attack_time=0, update_attack_time=0, spawn_valid=0, spawn fields=0, spawn_count=0, armed_index=0.
REQ-031 Reset asserted mid-operation SHALL abort any fetch or ack with no spawn and no update pulse on the following cycle.

Verification
REQ-032 Hold reset, then sync=0, attack_i=0, ROM[0].delay=50, current_time=100 -> update=1 in cycle 3 with next_attack_time=150; sync=1 next -> ARMED, update=0.
REQ-033 ARMED on index 0 with ROM[0]={type 2,x 100,y 200,life 30}; attack_i->1 and sync->0 together -> one-cycle spawn_valid with those fields, spawn_count=1, then fetch of ROM[1].
REQ-034 ARMED on index 5; attack_i->6 with sync held 1 -> spawn_valid once, state IDLE; later sync->0 -> fetch ROM[6] with rom_addr=6.
REQ-035 In ACK, hold sync=0 for 20 cycles while current_time advances 1000->1003, delay=10 -> update stays high; next_attack_time tracks 1010..1013; the value when sync rises is kept.
REQ-036 current_time=2^30-5, delay=10 -> next_attack_time=5; is_reset_stage=1 in ARMED with an attack_i change -> no spawn, IDLE.
REQ-037 Reset asserted during LATCH -> all outputs at reset values on the next cycle; spawn_count=0.
